// File: rtl/scan_sequencer_if.sv
// Control and status bundle between a scan controller and scan_sequencer.
// The master drives the scan request and its configuration; the slave
// (scan_sequencer) returns the row index, strobe and status pulses.
interface scan_sequencer_if #(
    parameter int SIZE  = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             cont;
    logic [SIZE-1:0]  last;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] blank;
    logic [SIZE-1:0]  sel;
    logic             en;
    logic             row_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output start, stop, cont, last, dwell, blank,
        input  sel, en, row_start, frame_done, busy
    );

    modport slave (
        input  start, stop, cont, last, dwell, blank,
        output sel, en, row_start, frame_done, busy
    );
endinterface

// File: rtl/scan_sequencer.sv
// Timed row-scan generator feeding a one-hot row decoder.
// Walks rows 0..last, holding each row active for a programmable dwell and
// optionally inserting an en-low blanking gap between rows. One-shot or
// continuous. Every output is a flop so sel and en move on the same edge.
module scan_sequencer #(
    parameter int SIZE  = 3,
    parameter int WIDTH = 1 << SIZE,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    scan_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    // Highest row the downstream decoder can address.
    localparam logic [SIZE-1:0] LAST_MAX = SIZE'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SIZE-1:0]  sel_q, sel_d;
    logic             en_q, en_d;
    logic             row_start_q, row_start_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cont_q, cont_d;
    logic [SIZE-1:0]  last_q, last_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] blank_q, blank_d;

    // A dwell of zero still gives the row one active cycle.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        logic [SIZE-1:0] next_sel;
        logic            last_row;

        state_d      = state_q;
        sel_d        = sel_q;
        en_d         = en_q;
        row_start_d  = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        cont_d       = cont_q;
        last_d       = last_q;
        dwell_d      = dwell_q;
        blank_d      = blank_q;

        last_row = (sel_q == last_q);
        next_sel = last_row ? '0 : sel_q + SIZE'(1);

        case (state_q)
            IDLE: begin
                sel_d  = '0;
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (bus.start && !bus.stop) begin
                    cont_d      = bus.cont;
                    last_d      = (bus.last > LAST_MAX) ? LAST_MAX : bus.last;
                    dwell_d     = at_least_one(bus.dwell);
                    blank_d     = bus.blank;
                    state_d     = ACTIVE;
                    en_d        = 1'b1;
                    row_start_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = at_least_one(bus.dwell);
                end
            end

            ACTIVE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Final active cycle of this row.
                    frame_done_d = last_row;
                    if (last_row && !cont_q) begin
                        state_d = IDLE;
                        sel_d   = '0;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end else if (blank_q != '0) begin
                        state_d = BLANK;
                        en_d    = 1'b0;
                        cnt_d   = blank_q;
                    end else begin
                        sel_d       = next_sel;
                        en_d        = 1'b1;
                        row_start_d = 1'b1;
                        cnt_d       = dwell_q;
                    end
                end
            end

            BLANK: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d     = ACTIVE;
                    sel_d       = next_sel;
                    en_d        = 1'b1;
                    row_start_d = 1'b1;
                    cnt_d       = dwell_q;
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, config shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            en_q         <= 1'b0;
            row_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            cont_q       <= 1'b0;
            last_q       <= '0;
            dwell_q      <= '0;
            blank_q      <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            row_start_q  <= row_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            cont_q       <= cont_d;
            last_q       <= last_d;
            dwell_q      <= dwell_d;
            blank_q      <= blank_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.row_start  = row_start_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a frame-schedule model checked every cycle,
// hand-computed scenarios, and a randomized soak.
module tb_scan_sequencer;

    localparam int SIZE  = 3;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [SIZE-1:0] sel;
        logic            en;
        logic            rs;
        logic            fd;
        logic            busy;
    } out_t;

    logic clk;
    logic rst_n;

    scan_sequencer_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

    scan_sequencer #(.SIZE(SIZE), .WIDTH(1 << SIZE), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    out_t q[$];
    out_t cur = '0;
    bit   pend_fd = 0;
    bit   m_cont;
    int   m_last, m_dwell, m_blank;

    function automatic out_t dut_out();
        out_t o;
        o.sel  = bus.sel;
        o.en   = bus.en;
        o.rs   = bus.row_start;
        o.fd   = bus.frame_done;
        o.busy = bus.busy;
        return o;
    endfunction

    function automatic out_t mk(int sel, bit en, bit rs, bit fd, bit busy);
        out_t o;
        o.sel  = SIZE'(sel);
        o.en   = en;
        o.rs   = rs;
        o.fd   = fd;
        o.busy = busy;
        return o;
    endfunction

    task automatic push(int sel, bit en, bit rs, bit busy);
        q.push_back(mk(sel, en, rs, pend_fd, busy));
        pend_fd = 0;
    endtask

    // One full pass over the rows, followed by what comes after the last row.
    task automatic build_frame();
        int d;
        d = (m_dwell == 0) ? 1 : m_dwell;
        for (int r = 0; r <= m_last; r++) begin
            for (int k = 0; k < d; k++) push(r, 1'b1, k == 0, 1'b1);
            if (r < m_last)
                for (int k = 0; k < m_blank; k++) push(r, 1'b0, 1'b0, 1'b1);
        end
        pend_fd = 1;
        if (!m_cont) push(0, 1'b0, 1'b0, 1'b0);
        else for (int k = 0; k < m_blank; k++) push(m_last, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                pend_fd = 0;
                cur     = '0;
            end else begin
                if (!cur.busy) begin
                    if (bus.start && !bus.stop) begin
                        m_cont  = bus.cont;
                        m_last  = int'(bus.last);
                        m_dwell = int'(bus.dwell);
                        m_blank = int'(bus.blank);
                        q.delete();
                        pend_fd = 0;
                        build_frame();
                    end
                end else if (bus.stop) begin
                    q.delete();
                    pend_fd = 0;
                end else if (q.size() == 0) begin
                    build_frame();
                end
                cur = (q.size() != 0) ? q.pop_front() : '0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if (dut_out() !== cur) begin
                n_fail++;
                $display("FAIL model t=%0t: got sel=%0d en=%0b rs=%0b fd=%0b busy=%0b required sel=%0d en=%0b rs=%0b fd=%0b busy=%0b",
                         $time, bus.sel, bus.en, bus.row_start, bus.frame_done, bus.busy,
                         cur.sel, cur.en, cur.rs, cur.fd, cur.busy);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, out_t exp);
        out_t act;
        act = dut_out();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sel=%0d en=%0b rs=%0b fd=%0b busy=%0b required sel=%0d en=%0b rs=%0b fd=%0b busy=%0b",
                     name, act.sel, act.en, act.rs, act.fd, act.busy,
                     exp.sel, exp.en, exp.rs, exp.fd, exp.busy);
        end
    endtask

    // Start asserted during "cycle 0"; returns positioned in cycle 1.
    task automatic start_scan(bit c, int l, int d, int b);
        bus.cont  = c;
        bus.last  = SIZE'(l);
        bus.dwell = CNT_W'(d);
        bus.blank = CNT_W'(b);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic idle_gap(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int os_sel[9]  = '{0, 0, 0, 1, 1, 1, 2, 2, 0};
        int os_en[9]   = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
        int os_rs[9]   = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
        int os_fd[9]   = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        int os_busy[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.cont  = 1'b0;
        bus.last  = '0;
        bus.dwell = '0;
        bus.blank = '0;
        idle_gap(3);
        chk("reset state", mk(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        idle_gap(2);

        // One-shot, dwell=2, blank=1, last=2.
        start_scan(1'b0, 2, 2, 1);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("oneshot c%0d", k + 1),
                mk(os_sel[k], os_en[k], os_rs[k], os_fd[k], os_busy[k]));
            tick();
        end
        chk("oneshot stays idle", mk(0, 0, 0, 0, 0));
        idle_gap(2);

        // Continuous, dwell=1, blank=0, last=3.
        start_scan(1'b1, 3, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("cont c%0d", k),
                mk((k - 1) % 4, 1, 1, (k > 1) && ((k - 1) % 4 == 0), 1));
            tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("cont stop", mk(0, 0, 0, 0, 0));
        idle_gap(2);

        // dwell=0, blank=0, last=0, one-shot.
        start_scan(1'b0, 0, 0, 0);
        chk("dwell0 c1", mk(0, 1, 1, 0, 1));
        tick();
        chk("dwell0 c2", mk(0, 0, 0, 1, 0));
        idle_gap(2);

        // Stop during the blank after row 1.
        start_scan(1'b0, 2, 2, 1);
        for (int c = 1; c < 6; c++) tick();
        chk("stop pre blank", mk(1, 0, 0, 0, 1));
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop in blank", mk(0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("stop no fd %0d", k), mk(0, 0, 0, 0, 0));
        end

        // start and stop together while idle.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("start+stop idle", mk(0, 0, 0, 0, 0));
        tick();
        chk("start+stop idle 2", mk(0, 0, 0, 0, 0));

        // Restart and last changed while busy: both ignored.
        start_scan(1'b0, 2, 2, 1);
        for (int c = 1; c <= 9; c++) begin
            if (c == 7) chk("busy ignore row2", mk(2, 1, 1, 0, 1));
            if (c == 9) chk("busy ignore done", mk(0, 0, 0, 1, 0));
            if (c == 3) begin
                bus.last  = '0;
                bus.start = 1'b1;
            end
            if (c == 4) bus.start = 1'b0;
            tick();
        end
        start_scan(1'b0, 0, 2, 1);
        chk("new last c1", mk(0, 1, 1, 0, 1));
        tick();
        chk("new last c2", mk(0, 1, 0, 0, 1));
        tick();
        chk("new last c3", mk(0, 0, 0, 1, 0));
        idle_gap(2);

        // Asynchronous reset mid-scan.
        start_scan(1'b1, 5, 3, 2);
        idle_gap(4);
        rst_n = 1'b0;
        #1;
        chk("async reset", mk(0, 0, 0, 0, 0));
        idle_gap(2);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post reset idle %0d", k), mk(0, 0, 0, 0, 0));
        end

        // Randomized soak; config inputs churn every cycle.
        for (int i = 0; i < 4000; i++) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.stop  = ($urandom_range(0, 59) == 0);
            bus.cont  = $urandom_range(0, 1);
            bus.last  = SIZE'($urandom_range(0, 7));
            bus.dwell = CNT_W'($urandom_range(0, 4));
            bus.blank = CNT_W'($urandom_range(0, 3));
            tick();
        end

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        idle_gap(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
